// File: rtl/cpu_pkg.sv
// Shared CPU definitions: funct3 access-size/sign codes, size fields and the
// mem_bus_ctrl state encoding, plus the alignment rule used at acceptance.
// Latency: n/a (types and constants only). Backpressure: n/a.
package cpu_pkg;

  // funct3 codes for loads/stores (bit 2 set = zero-extending load)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] alone gives the access size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Bus-ack timeout counter width (used only with MEM_TIMEOUT_EN)
  localparam int TO_CNT_W = 16;

  typedef enum logic [1:0] {
    MBC_IDLE = 2'd0,
    MBC_BUS  = 2'd1,
    MBC_DONE = 2'd2
  } mbc_state_e;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
  // Unknown sizes are treated as words, the strictest rule.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// External memory bus between mem_bus_ctrl (master) and a memory slave.
// Latency: n/a. Backpressure: slave stretches a cycle by withholding bus_ack.
// Signals: bus_req/bus_we/bus_addr/bus_be/bus_wdata (master->slave),
//          bus_ack/bus_rdata (slave->master, rdata valid with ack).
interface mem_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a bus read word and sign/zero-extends it.
// Latency: combinational. Backpressure: none.
// Ports: word_i (bus read word), off_i (addr[1:0]), funct3_i (load type), data_o (MDR value).
module mem_load_align
  import cpu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Multicycle-CPU load/store unit: turns a mem_read/mem_write request edge into one bus cycle.
// Latency: accept edge -> BUS next cycle -> DONE one cycle after bus_ack (min 2 cycles); misaligned -> DONE in 1.
// Backpressure: holds BUS (mem_busy=1) until bus_ack; with MEM_TIMEOUT_EN defined, aborts after TIMEOUT_CYCLES.
// Ports: clk, reset (async, active-high); mem_read/mem_write/funct3/addr/wdata from control;
//        rdata/mem_busy/mem_done/mem_err to control; bus (mem_bus_ctrl_if.master) to memory.
module mem_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        mem_err,
  mem_bus_ctrl_if.master bus
);

  mbc_state_e  state_q, state_d;
  logic        err_q, err_d;
  logic        prev_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        req_lvl;
  logic        accept;
  logic        misal;
  logic        in_bus;
  logic        timeout_hit;
  logic [3:0]  be_lanes;
  logic [31:0] wdata_lanes;
  logic [31:0] load_data;

  // Reset clears prev_q, so a level already high at reset release is an edge.
  assign req_lvl = mem_read | mem_write;
  assign accept  = (state_q == MBC_IDLE) && req_lvl && !prev_q;
  assign misal   = is_misaligned(funct3, addr[1:0]);
  assign in_bus  = (state_q == MBC_BUS);

`ifdef MEM_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q;

  // Counts BUS cycles without ack; the last allowed cycle is TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (in_bus && !bus.bus_ack) begin
      to_cnt_q <= to_cnt_q + TO_CNT_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_hit = (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      MBC_IDLE: begin
        if (accept) begin
          state_d = misal ? MBC_DONE : MBC_BUS;
          err_d   = misal;
        end
      end
      MBC_BUS: begin
        if (bus.bus_ack) begin
          state_d = MBC_DONE;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = MBC_DONE;
          err_d   = 1'b1;
        end
      end
      MBC_DONE: begin
        state_d = MBC_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = MBC_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MBC_IDLE;
      err_q   <= 1'b0;
      prev_q  <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      prev_q  <= req_lvl;
      if (accept) begin
        we_q    <= mem_write;  // read+write together is a store
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  mem_load_align u_load_align (
    .word_i   (bus.bus_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  // MDR only changes on a completed load, or clears on a rejected misaligned load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (accept && misal && !mem_write) begin
      rdata_q <= '0;
    end else if (in_bus && bus.bus_ack && !we_q) begin
      rdata_q <= load_data;
    end
  end

  // Store lane steering; loads always read the whole word.
  always_comb begin
    be_lanes    = 4'b1111;
    wdata_lanes = wdata_q;
    if (we_q) begin
      case (f3_q[1:0])
        SZ_B: begin
          be_lanes    = 4'b0001 << addr_q[1:0];
          wdata_lanes = {4{wdata_q[7:0]}};
        end
        SZ_H: begin
          be_lanes    = addr_q[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata_q[15:0]}};
        end
        default: begin
          be_lanes    = 4'b1111;
          wdata_lanes = wdata_q;
        end
      endcase
    end
  end

  // Bus outputs are gated by the state so they drop with an asynchronous reset.
  assign bus.bus_req   = in_bus;
  assign bus.bus_we    = in_bus & we_q;
  assign bus.bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.bus_be    = in_bus ? be_lanes : 4'b0000;
  assign bus.bus_wdata = (in_bus && we_q) ? wdata_lanes : 32'h0;

  assign rdata    = rdata_q;
  assign mem_busy = in_bus;
  assign mem_done = (state_q == MBC_DONE);
  assign mem_err  = (state_q == MBC_DONE) & err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        mem_busy, mem_done, mem_err;

  int tests = 0;
  int fails = 0;
  int req_cyc, done_cyc, done_at;

  always #5 clk = ~clk;

  mem_bus_ctrl_if bus_if ();

  mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .bus       (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    tick(); tick();

    // reset state
    check("rst_req",   bus_if.bus_req, 0);
    check("rst_we",    bus_if.bus_we, 0);
    check("rst_addr",  bus_if.bus_addr, 0);
    check("rst_be",    bus_if.bus_be, 0);
    check("rst_wdata", bus_if.bus_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy",  mem_busy, 0);
    check("rst_done",  mem_done, 0);
    check("rst_err",   mem_err, 0);
    reset = 1'b0;
    tick();

    // sw 0x100, ack in third BUS cycle, inputs change after acceptance
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hDEADBEEF;
    tick();
    check("sw_req",   bus_if.bus_req, 1);
    check("sw_we",    bus_if.bus_we, 1);
    check("sw_addr",  bus_if.bus_addr, 32'h100);
    check("sw_be",    bus_if.bus_be, 4'hF);
    check("sw_wdata", bus_if.bus_wdata, 32'hDEADBEEF);
    check("sw_busy1", mem_busy, 1);
    mem_write = 1'b0; addr = 32'h555; wdata = 32'h0; funct3 = 3'b000;
    tick();
    check("sw_hold_addr",  bus_if.bus_addr, 32'h100);
    check("sw_hold_wdata", bus_if.bus_wdata, 32'hDEADBEEF);
    check("sw_busy2", mem_busy, 1);
    tick();
    check("sw_busy3", mem_busy, 1);
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    check("sw_done", mem_done, 1);
    check("sw_err",  mem_err, 0);
    check("sw_busy_off", mem_busy, 0);
    check("sw_req_off",  bus_if.bus_req, 0);
    tick();
    check("sw_done_pulse", mem_done, 0);

    // lb 0x203 on 0x80FF1234 -> sign-extended 0x80
    mem_read = 1'b1; funct3 = 3'b000; addr = 32'h203;
    tick();
    check("lb_req",  bus_if.bus_req, 1);
    check("lb_we",   bus_if.bus_we, 0);
    check("lb_be",   bus_if.bus_be, 4'hF);
    check("lb_addr", bus_if.bus_addr, 32'h200);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h80FF1234; mem_read = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0;
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_done",  mem_done, 1);
    tick();

    // lbu on the same data -> zero-extended
    mem_read = 1'b1; funct3 = 3'b100; addr = 32'h203;
    tick();
    bus_if.bus_ack = 1'b1; mem_read = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0;
    check("lbu_rdata", rdata, 32'h00000080);
    tick();

    // sh 0x12 -> upper half lanes, halfword replicated; rdata untouched
    mem_write = 1'b1; funct3 = 3'b001; addr = 32'h12; wdata = 32'h0000ABCD;
    tick();
    check("sh_addr",  bus_if.bus_addr, 32'h10);
    check("sh_be",    bus_if.bus_be, 4'hC);
    check("sh_wdata", bus_if.bus_wdata, 32'hABCDABCD);
    check("sh_we",    bus_if.bus_we, 1);
    bus_if.bus_ack = 1'b1; mem_write = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0;
    check("sh_done",  mem_done, 1);
    check("sh_rdata_kept", rdata, 32'h00000080);
    tick();

    // sb 0x31 -> lane 1, byte replicated
    mem_write = 1'b1; funct3 = 3'b000; addr = 32'h31; wdata = 32'h12345655;
    tick();
    check("sb_addr",  bus_if.bus_addr, 32'h30);
    check("sb_be",    bus_if.bus_be, 4'h2);
    check("sb_wdata", bus_if.bus_wdata, 32'h55555555);
    bus_if.bus_ack = 1'b1; mem_write = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0;
    tick();

    // lh 0x2 on 0x80017FFF -> upper half 0x8001 sign-extended
    mem_read = 1'b1; funct3 = 3'b001; addr = 32'h2;
    tick();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h80017FFF; mem_read = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0;
    check("lh_rdata", rdata, 32'hFFFF8001);
    tick();

    // lw 0x44 passes the word unchanged
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h44;
    tick();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678; mem_read = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0;
    check("lw_rdata", rdata, 32'h12345678);
    tick();

    // ack while idle is ignored
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFFFFFF;
    tick(); tick();
    bus_if.bus_ack = 1'b0;
    check("idle_ack_rdata", rdata, 32'h12345678);
    check("idle_ack_done",  mem_done, 0);
    check("idle_ack_busy",  mem_busy, 0);

    // misaligned lw 0x101: no bus cycle, error pulse, rdata cleared
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h101;
    tick();
    check("mis_lw_req",   bus_if.bus_req, 0);
    check("mis_lw_done",  mem_done, 1);
    check("mis_lw_err",   mem_err, 1);
    check("mis_lw_rdata", rdata, 0);
    mem_read = 1'b0;
    tick();
    check("mis_lw_done_pulse", mem_done, 0);
    check("mis_lw_err_pulse",  mem_err, 0);

    // misaligned sh 0x13
    mem_write = 1'b1; funct3 = 3'b001; addr = 32'h13; wdata = 32'h1;
    tick();
    check("mis_sh_req", bus_if.bus_req, 0);
    check("mis_sh_err", mem_err, 1);
    mem_write = 1'b0;
    tick();

    // level held 5 cycles, ack on first BUS cycle -> exactly one transaction
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40; bus_if.bus_rdata = 32'hCAFEF00D;
    req_cyc = 0; done_cyc = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_if.bus_req) req_cyc++;
      if (mem_done) begin
        done_cyc++;
        done_at = i;
      end
      bus_if.bus_ack = bus_if.bus_req;
      if (i == 4) mem_read = 1'b0;
    end
    bus_if.bus_ack = 1'b0;
    check("hold_req_cycles", req_cyc, 1);
    check("hold_done_count", done_cyc, 1);
    check("hold_done_at",    done_at, 1);
    check("hold_rdata",      rdata, 32'hCAFEF00D);

    // reset in BUS: bus_req drops at once, no done; held level accepted on release
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
    tick();
    check("rb_req_pre", bus_if.bus_req, 1);
    #1 reset = 1'b1;
    #1;
    check("rb_req_async",  bus_if.bus_req, 0);
    check("rb_busy_async", mem_busy, 0);
    check("rb_rdata",      rdata, 0);
    tick();
    check("rb_no_done", mem_done, 0);
    reset = 1'b0;
    tick();
    check("rb_rel_busy", mem_busy, 1);
    check("rb_rel_addr", bus_if.bus_addr, 32'h80);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0BADF00D; mem_read = 1'b0;
    tick();
    bus_if.bus_ack = 1'b0;
    check("rb_rel_done",  mem_done, 1);
    check("rb_rel_rdata", rdata, 32'h0BADF00D);
    tick();

`ifdef MEM_TIMEOUT_EN
    // no ack: abort after 4 BUS cycles with error, rdata kept
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    tick();
    mem_read = 1'b0;
    check("to_busy1", mem_busy, 1);
    tick(); tick(); tick();
    check("to_busy4", mem_busy, 1);
    check("to_err4",  mem_err, 0);
    tick();
    check("to_done",  mem_done, 1);
    check("to_err",   mem_err, 1);
    check("to_rdata", rdata, 32'h0BADF00D);
    tick();
    check("to_done_pulse", mem_done, 0);
`else
    // no timeout: BUS waits indefinitely for ack
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    tick();
    mem_read = 1'b0;
    repeat (20) tick();
    check("wait_busy", mem_busy, 1);
    check("wait_req",  bus_if.bus_req, 1);
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    check("wait_done", mem_done, 1);
    check("wait_err",  mem_err, 0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
